// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: Diff = a - b - Bin, one bit per clock,
// with start/done handshake and results held until the next operation completes.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Ovf
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_res;
   logic               r_br;
   logic [CNT_W-1:0]   r_cnt;
   logic               w_accept;
   logic               w_last;
   logic               w_d;
   logic               w_br_nxt;

   // Full-subtractor cell on the current LSBs
   always_comb begin
      w_d      = r_a[0] ^ r_b[0] ^ r_br;
      w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
      w_accept = start && (r_state != S_SHIFT);
      w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SHIFT;
         S_SHIFT: if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = start ? S_SHIFT : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs; result outputs move only on the last bit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_res <= '0;
         r_br  <= 1'b0;
         r_cnt <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         Diff  <= '0;
         Bout  <= 1'b0;
         Ovf   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= Bin;
            r_cnt <= '0;
         end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_nxt;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
               Diff <= {w_d, r_res[WIDTH-1:1]};
               Bout <= w_br_nxt;
               // Borrow into the MSB stage versus borrow out of it
               Ovf  <= r_br ^ w_br_nxt;
            end
         end
         busy <= (w_state_nxt == S_SHIFT);
         done <= (w_state_nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, ignored-start,
// mid-operation reset, back-to-back operation and a randomized run.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;
   logic         Ovf;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .Diff  (Diff),
      .Bout  (Bout),
      .Ovf   (Ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic, unsigned for borrow, signed for overflow
   function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tbin, output logic [W-1:0] d,
                                 output logic bo, output logic ov);
      int ud;
      int sd;
      ud = int'(ta) - int'(tb) - int'(tbin);
      sd = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
      d  = W'(ud);
      bo = (ud < 0);
      ov = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
   endfunction

   // One operation; glitch >= 0 pulses start with junk operands on that cycle
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input int glitch, input string tag);
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int           n;
      int           bc;
      model(ta, tb, tbin, ed, eb, eo);
      a = ta; b = tb; Bin = tbin; start = 1'b1;
      step();
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); Bin = 1'($urandom);
      n = 0; bc = 0;
      while (!done && n < 40) begin
         if (busy) bc++;
         if (n == glitch) begin
            start = 1'b1; a = 8'h11; b = 8'h11;
         end
         step();
         start = 1'b0;
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done), 32'd1);
      chk({tag, "_latency"}, 32'(n), 32'(W));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(W));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_diff"}, 32'(Diff), 32'(ed));
      chk({tag, "_bout"}, 32'(Bout), 32'(eb));
      chk({tag, "_ovf"}, 32'(Ovf), 32'(eo));
      step();
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
      chk({tag, "_diff_hold"}, 32'(Diff), 32'(ed));
   endtask

   initial begin
      int n;
      int dcount;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Bin = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(Diff), 32'd0);
      chk("rst_bout", 32'(Bout), 32'd0);
      chk("rst_ovf",  32'(Ovf),  32'd0);
      rst_n = 1'b1;
      step();

      run_op(8'h50, 8'h20, 1'b0, -1, "t1");
      run_op(8'h20, 8'h50, 1'b0, -1, "t2a");
      run_op(8'h80, 8'h01, 1'b0, -1, "t2b");
      run_op(8'h00, 8'h00, 1'b1, -1, "t3a");
      run_op(8'h7F, 8'hFF, 1'b0, -1, "t3b");
      run_op(8'h80, 8'h7F, 1'b1, -1, "t3c");
      run_op(8'h50, 8'h20, 1'b0, 2, "t4_ignored_start");

      // Reset in the middle of an operation discards everything
      a = 8'h5A; b = 8'h21; Bin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(done), 32'd0);
      chk("t5_diff", 32'(Diff), 32'd0);
      chk("t5_bout", 32'(Bout), 32'd0);
      chk("t5_ovf",  32'(Ovf),  32'd0);
      dcount = 0;
      repeat (12) begin
         step();
         if (done) dcount++;
      end
      chk("t5_no_done", 32'(dcount), 32'd0);
      chk("t5_diff_stays", 32'(Diff), 32'd0);

      // start held high: one result every WIDTH+1 cycles
      a = 8'hA5; b = 8'h5A; Bin = 1'b0; start = 1'b1;
      for (int p = 0; p < 3; p++) begin
         n = 0;
         do begin
            step();
            n++;
            if (n == 1) chk("t6_busy_restart", 32'(busy), 32'd1);
         end while (!done && n < 40);
         chk("t6_period", 32'(n), 32'(W + 1));
         chk("t6_diff", 32'(Diff), 32'h4B);
         chk("t6_bout", 32'(Bout), 32'd0);
         chk("t6_ovf",  32'(Ovf),  32'd1);
      end
      start = 1'b0;
      step();
      step();
      chk("t6_idle", 32'(busy), 32'd0);

      for (int i = 0; i < 1000; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom),
                (($urandom % 4) == 0) ? int'($urandom % W) : -1, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor; the inverse operation of the team's combinational full adder.
- Computes Diff = a - b - Bin over WIDTH bits using one full-subtractor cell and a borrow flip-flop, one bit per clock.
- Start/done handshake; results are held until the next accepted start.
- Used where area matters more than latency, and as a sequential-design training block.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request; accepted only when busy=0
a  input  WIDTH  minuend, sampled on the accepting edge
b  input  WIDTH  subtrahend, sampled on the accepting edge
Bin  input  1  borrow-in, sampled on the accepting edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: results valid
Diff  output  WIDTH  difference a - b - Bin mod 2^WIDTH
Bout  output  1  unsigned borrow-out (1 when a < b + Bin)
Ovf  output  1  signed overflow (two's complement)

Behaviour:
- Reset: rst_n=0 at a rising edge forces state IDLE and clears all registers. Outputs become busy=0, done=0, Diff=0, Bout=0, Ovf=0. This applies at any time, including mid-operation; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE / DONE, start=1 at edge k:
  - latch a, b and Bin (borrow reg = Bin);
  - clear the bit counter;
  - go to SHIFT; busy=1 from edge k onward.
  - Otherwise hold. DONE always moves to IDLE after one cycle unless start=1.
- SHIFT, each edge, using current LSBs ai, bi and borrow br:
  - d = ai ^ bi ^ br;
  - br' = (~ai & bi) | (~(ai ^ bi) & br);
  - shift operand registers right by 1;
  - shift d into the MSB of the result shift register;
  - counter += 1.
  - On the edge that processes bit WIDTH-1, also capture the borrow into the MSB stage (br before that update) for Ovf.
- SHIFT -> DONE on the edge processing bit WIDTH-1 (counter == WIDTH-1). On that edge:
  - Diff <= final result register;
  - Bout <= br';
  - Ovf <= br_in_msb ^ br';
  - done=1, busy=0 for exactly one cycle.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH. busy is high for WIDTH cycles.
- Diff, Bout and Ovf change only on the DONE transition or reset. They are stable during a following operation until its DONE.
- start while busy=1 is ignored: no restart, and input changes have no effect.
- start=1 held continuously runs back-to-back operations. Each done pulse is followed by busy the next cycle (restart from DONE).
- a, b and Bin may change freely after the accepting edge.
- Result is arithmetic mod 2^WIDTH.
- Identities: {Bout,Diff} = {1'b0,a} - {1'b0,b} - Bin; Ovf = (a[MSB] != b[MSB]) & (Diff[MSB] != a[MSB]) when Bin=0.

Test Plan:
1. WIDTH=8, a=0x50, b=0x20, Bin=0, start pulse -> busy 8 cycles, done pulse 9 cycles after accept, Diff=0x30, Bout=0, Ovf=0.
2. a=0x20, b=0x50, Bin=0 -> Diff=0xD0, Bout=1, Ovf=0; a=0x80, b=0x01, Bin=0 -> Diff=0x7F, Bout=0, Ovf=1.
3. a=0x00, b=0x00, Bin=1 -> Diff=0xFF, Bout=1, Ovf=0; a=0x7F, b=0xFF, Bin=0 -> Diff=0x80, Bout=1, Ovf=1.
4. Start a=0x50, b=0x20. Three cycles later pulse start with a=0x11, b=0x11 -> ignored; result 0x30, single done pulse.
5. Start an operation, assert rst_n=0 for one cycle at bit 4 -> next cycle busy=0, done=0, Diff=0, Bout=0, Ovf=0; no done pulse follows.
6. start held high with a=0xA5, b=0x5A -> done every 9 cycles, each with Diff=0x4B, Bout=0, Ovf=1. Random 1000-vector run vs. reference {Bout,Diff} and Ovf identities -> zero mismatches.
